load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning data memory size in 32-bit words (power of two).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  a request is presented.
REQ-005 SHALL have port req_ready  output  1  the unit can accept a request this cycle.
REQ-006 SHALL have port mem_read  input  1  the request is a load.
REQ-007 SHALL have port mem_write  input  1  the request is a store.
REQ-008 SHALL have port funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port write_data  input  32  store data, taken from low-order bytes.
REQ-011 SHALL have port resp_valid  output  1  single-cycle completion pulse.
REQ-012 SHALL have port mem_data  output  32  extended load result, feeding the writeback select.
REQ-013 SHALL have port mem_fault  output  1  the completing request was misaligned or illegal.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accept, ACCESS->RESP always, RESP->IDLE always.
REQ-015 SHALL drive req_ready=1 only in IDLE; accept = req_valid & req_ready & (mem_read ^ mem_write).
REQ-016 SHALL ignore requests with mem_read==mem_write: no accept, no response, no memory effect.
REQ-017 SHALL register addr, funct3, write_data and op type on accept; later input changes SHALL NOT affect that request.
REQ-018 SHALL assert resp_valid for exactly one cycle, in RESP, two cycles after the accept edge; throughput one request per 3 cycles.
REQ-019 SHALL index the word array with addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-020 SHALL fault when H/HU has addr[0]=1, when W has addr[1:0]!=00, or when funct3 is 011, 110 or 111 (store with 100/101 also faults).
REQ-021 SHALL commit a non-faulting store at the end of ACCESS, writing only the addressed byte lanes (SB 1, SH 2, SW 4).
REQ-022 SHALL, for a non-faulting load, select the addressed byte or half and sign-extend (B, H) or zero-extend (BU, HU); W SHALL be passed unchanged.
REQ-023 SHALL update mem_data in RESP only for loads: non-faulting loads load the result, faulting loads load 0; stores leave mem_data unchanged.
REQ-024 SHALL assert mem_fault together with resp_valid only, and SHALL perform no memory write for a faulting request.
REQ-025 SHALL make a load immediately following a store to the same word return the stored data (write commits before the next ACCESS).

Reset
REQ-026 SHALL, on reset, force state IDLE, resp_valid=0, mem_fault=0, mem_data=0; req_ready=1 in the cycle after reset deasserts.
REQ-027 SHALL give reset priority: reset high during ACCESS aborts the request, with no write committed and no response issued.
REQ-028 SHALL NOT clear memory array contents on reset.

Structure
REQ-029 SHALL place funct3 encodings, the FSM state encoding and the DEPTH_WORDS default in shared package lsu_pkg.
REQ-030 SHALL implement byte/half selection and extension in one combinational sub-module, load_extend; all other logic SHALL be in load_store_unit.

Verification
REQ-031 SHALL check a store with SW at 0x10, data 0xDEADBEEF, followed by LW at 0x10 -> mem_data=0xDEADBEEF, resp_valid 2 cycles after each accept.
REQ-032 SHALL check word 0x10=0xDEADBEEF: LB at 0x13 -> 0xFFFFFFDE; LBU at 0x13 -> 0x000000DE; LH at 0x12 -> 0xFFFFDEAD; LHU at 0x10 -> 0x0000BEEF.
REQ-033 SHALL check SB 0x55 at 0x11 on word 0xDEADBEEF -> a following LW returns 0xDEAD55EF.
REQ-034 SHALL check that SW at 0x22 and LH at 0x01 each give mem_fault=1; the word at 0x20 stays unchanged; the LH returns mem_data=0.
REQ-035 SHALL check that reset asserted in ACCESS of an SW at 0x30 produces no resp_valid and leaves the prior word at 0x30 intact; req_ready=1 after reset.
REQ-036 SHALL check that mem_read=mem_write=1 with req_valid=1 produces no response and req_ready stays 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access encodings,
// FSM state encoding, default memory depth, request payload and the
// access-legality check.
package lsu_pkg;

   localparam int unsigned DEPTH_WORDS_DEFAULT = 256;
   localparam int unsigned XLEN                = 32;

   // funct3 access size/sign encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // Request payload captured on accept
   typedef struct packed {
      logic            is_store;
      logic [2:0]      funct3;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } lsu_req_t;

   // Misaligned halves/words, reserved encodings and unsigned stores fault
   function automatic logic access_fault(input logic       is_store,
                                         input logic [2:0] f3,
                                         input logic [1:0] off);
      logic fault;
      fault = 1'b1;
      case (f3)
         F3_B:    fault = 1'b0;
         F3_H:    fault = off[0];
         F3_W:    fault = (off != 2'b00);
         F3_BU:   fault = is_store;
         F3_HU:   fault = is_store | off[0];
         default: fault = 1'b1;
      endcase
      return fault;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Load data path: picks the addressed byte or half out of a memory word and
// sign- or zero-extends it to 32 bits; words pass through unchanged.
// Ports:
//   word       - full 32-bit word read from the data memory
//   byte_off   - addr[1:0] of the load
//   funct3     - access size/sign
//   ext_data_c - extended result (combinational)
module load_extend
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      byte_off,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] ext_data_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection
   always_comb begin
      byte_sel = word[7:0];
      case (byte_off)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = byte_off[1] ? word[31:16] : word[15:0];
   end

   // Extension by access type; illegal encodings yield zero
   always_comb begin
      ext_data_c = '0;
      case (funct3)
         F3_B:    ext_data_c = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    ext_data_c = {{16{half_sel[15]}}, half_sel};
         F3_W:    ext_data_c = word;
         F3_BU:   ext_data_c = {24'd0, byte_sel};
         F3_HU:   ext_data_c = {16'd0, half_sel};
         default: ext_data_c = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit with a private word-organised data memory.
// A request is accepted in IDLE, the memory is accessed in ACCESS (stores
// commit at its end), and a one-cycle response is issued in RESP.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   req_valid/req_ready  - request handshake (ready only in IDLE)
//   mem_read, mem_write  - op type; both or neither is ignored
//   funct3               - access size/sign
//   addr, write_data     - byte address, store data (low-order bytes)
//   resp_valid           - single-cycle completion pulse
//   mem_data             - extended load result (held across stores)
//   mem_fault            - completing request was misaligned or illegal
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT
)
(
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] write_data,
   output logic            resp_valid,
   output logic [XLEN-1:0] mem_data,
   output logic            mem_fault
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   logic [1:0]       state;
   logic [1:0]       next_state;
   lsu_req_t         r_req;
   logic             accept_c;
   logic             commit_c;
   logic             fault_c;
   logic [IDX_W-1:0] widx;
   logic [XLEN-1:0]  rd_word;
   logic [XLEN-1:0]  ext_data_c;
   logic [XLEN-1:0]  st_data_c;
   logic [3:0]       st_be_c;
   logic             unused_addr_hi;

   logic [XLEN-1:0]  mem [DEPTH_WORDS];

   // Upper address bits are deliberately ignored so accesses wrap
   assign widx           = r_req.addr[IDX_W+1:2];
   assign unused_addr_hi = ^r_req.addr[XLEN-1:IDX_W+2];
   assign rd_word        = mem[widx];
   assign fault_c        = access_fault(r_req.is_store, r_req.funct3, r_req.addr[1:0]);

   // Next-state and handshake decode
   always_comb begin
      next_state = state;
      accept_c   = 1'b0;
      commit_c   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid && req_ready && (mem_read ^ mem_write)) begin
               accept_c   = 1'b1;
               next_state = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            commit_c   = r_req.is_store & ~fault_c;
            next_state = ST_RESP;
         end
         ST_RESP:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // Store lane enables and lane-replicated data
   always_comb begin
      st_be_c   = 4'b0000;
      st_data_c = '0;
      case (r_req.funct3[1:0])
         2'b00: begin
            st_be_c   = 4'b0001 << r_req.addr[1:0];
            st_data_c = {4{r_req.wdata[7:0]}};
         end
         2'b01: begin
            st_be_c   = r_req.addr[1] ? 4'b1100 : 4'b0011;
            st_data_c = {2{r_req.wdata[15:0]}};
         end
         default: begin
            st_be_c   = 4'b1111;
            st_data_c = r_req.wdata;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Registered outputs; response fields are loaded on the ACCESS->RESP edge
   always_ff @(posedge clk) begin
      if (reset) begin
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         mem_fault  <= 1'b0;
         mem_data   <= '0;
      end else begin
         req_ready  <= (next_state == ST_IDLE);
         resp_valid <= (state == ST_ACCESS);
         mem_fault  <= (state == ST_ACCESS) & fault_c;
         if ((state == ST_ACCESS) && !r_req.is_store) begin
            mem_data <= fault_c ? '0 : ext_data_c;
         end
      end
   end

   // Request capture; later input changes do not disturb the request
   always_ff @(posedge clk) begin
      if (!reset && accept_c) begin
         r_req.is_store <= mem_write;
         r_req.funct3   <= funct3;
         r_req.addr     <= addr;
         r_req.wdata    <= write_data;
      end
   end

   // Data memory: byte-lane writes, never cleared by reset
   always_ff @(posedge clk) begin
      if (!reset && commit_c) begin
         for (int i = 0; i < 4; i++) begin
            if (st_be_c[i]) begin
               mem[widx][8*i +: 8] <= st_data_c[8*i +: 8];
            end
         end
      end
   end

   load_extend u_load_extend (
      .word       (rd_word),
      .byte_off   (r_req.addr[1:0]),
      .funct3     (r_req.funct3),
      .ext_data_c (ext_data_c)
   );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit.
module tb_load_store_unit;
   import lsu_pkg::*;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        exp_fault;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        resp_valid;
   logic [31:0] mem_data;
   logic        mem_fault;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   load_store_unit #(.DEPTH_WORDS(256)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .funct3     (funct3),
      .addr       (addr),
      .write_data (write_data),
      .resp_valid (resp_valid),
      .mem_data   (mem_data),
      .mem_fault  (mem_fault)
   );

   function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] ed, input logic ef);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd;
      v.exp_data = ed; v.exp_fault = ef;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (req_ready) begin
            seen = 1'b1;
            break;
         end
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   // Issue one request and check latency, data, fault and pulse width
   task automatic do_req(input int id, input vec_t v);
      int lat;
      wait_ready($sformatf("v%0d_ready", id));
      req_valid  = 1'b1;
      mem_read   = v.rd;
      mem_write  = v.wr;
      funct3     = v.f3;
      addr       = v.addr;
      write_data = v.wdata;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      mem_read   = 1'($urandom);
      mem_write  = 1'($urandom);
      funct3     = 3'($urandom);
      addr       = $urandom;
      write_data = $urandom;
      lat = 0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) chk($sformatf("v%0d_busy", id), 32'(req_ready), 32'd0);
         if (resp_valid) begin
            lat = k;
            break;
         end
      end
      chk($sformatf("v%0d_lat", id), 32'(lat), 32'd2);
      chk($sformatf("v%0d_data", id), mem_data, v.exp_data);
      chk($sformatf("v%0d_fault", id), 32'(mem_fault), 32'(v.exp_fault));
      @(negedge clk);
      chk($sformatf("v%0d_pulse", id), 32'({resp_valid, mem_fault}), 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      funct3     = 3'b000;
      addr       = '0;
      write_data = '0;

      //           rd    wr    f3      addr          wdata         exp_data      fault
      vecs.push_back(mk(1'b0, 1'b1, F3_W,  32'h10,       32'hDEADBEEF, 32'h00000000, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'h10,       32'h0,        32'hDEADBEEF, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, F3_B,  32'h13,       32'h0,        32'hFFFFFFDE, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, F3_BU, 32'h13,       32'h0,        32'h000000DE, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, F3_H,  32'h12,       32'h0,        32'hFFFFDEAD, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, F3_HU, 32'h10,       32'h0,        32'h0000BEEF, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, F3_B,  32'h10,       32'h0,        32'hFFFFFFEF, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, F3_BU, 32'h11,       32'h0,        32'h000000BE, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, F3_B,  32'h11,       32'hAAAAAA55, 32'h000000BE, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'h10,       32'h0,        32'hDEAD55EF, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, F3_W,  32'h20,       32'h12345678, 32'hDEAD55EF, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, F3_W,  32'h22,       32'hCAFEF00D, 32'hDEAD55EF, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'h20,       32'h0,        32'h12345678, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, F3_H,  32'h01,       32'h0,        32'h00000000, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1, F3_H,  32'h22,       32'hFFFFABCD, 32'h00000000, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'h20,       32'h0,        32'hABCD5678, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'h80000410, 32'h0,        32'hDEAD55EF, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, F3_BU, 32'h20,       32'h0,        32'hDEAD55EF, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, 3'b011, 32'h20,      32'h0,        32'h00000000, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, F3_HU, 32'h23,       32'h0,        32'h00000000, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'h21,       32'h0,        32'h00000000, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, F3_HU, 32'h22,       32'h0,        32'h0000ABCD, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, F3_H,  32'h22,       32'h0,        32'hFFFFABCD, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, F3_W,  32'h30,       32'h11112222, 32'hFFFFABCD, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 3'b110, 32'h30,      32'h0,        32'h00000000, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1, 3'b111, 32'h30,      32'h0,        32'h00000000, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'h30,       32'h0,        32'h11112222, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, F3_B,  32'h33,       32'h00000080, 32'h11112222, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, F3_B,  32'h33,       32'h0,        32'hFFFFFF80, 1'b0));

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mem_fault", 32'(mem_fault), 32'd0);
      chk("rst_mem_data", mem_data, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);

      foreach (vecs[i]) do_req(i, vecs[i]);

      // Reset during ACCESS of a store aborts it
      wait_ready("abort_ready");
      req_valid  = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b1;
      funct3     = F3_W;
      addr       = 32'h30;
      write_data = 32'h99999999;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      reset     = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_mem_data", mem_data, 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("abort_no_resp%0d", k), 32'(resp_valid), 32'd0);
         @(negedge clk);
      end
      do_req(100, mk(1'b1, 1'b0, F3_W, 32'h30, 32'h0, 32'h80112222, 1'b0));

      // Both read and write set: ignored entirely
      @(negedge clk);
      req_valid  = 1'b1;
      mem_read   = 1'b1;
      mem_write  = 1'b1;
      funct3     = F3_W;
      addr       = 32'h30;
      write_data = 32'h0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("both_ready%0d", k), 32'(req_ready), 32'd1);
         chk($sformatf("both_no_resp%0d", k), 32'(resp_valid), 32'd0);
      end
      req_valid = 1'b0;
      do_req(101, mk(1'b1, 1'b0, F3_W, 32'h30, 32'h0, 32'h80112222, 1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
